// File: rtl/npu_pkg.sv
// Shared types and sizing helpers for the NPU dot-product datapath.
package npu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } dot_state_t;

  localparam int NPU_DATA_W  = 8;
  localparam int NPU_VEC_LEN = 32;

  // Full-precision width of a VEC_LEN-term sum of DATA_W x DATA_W products.
  function automatic int dot_acc_w(input int data_w, input int vec_len);
    return 2 * data_w + $clog2(vec_len);
  endfunction

endpackage

// File: rtl/dot_lane_mult.sv
// LANES parallel multipliers with sign/zero extension and an adder tree;
// the lane sum is registered as the partial sum when en is high.
module dot_lane_mult #(
  parameter int DATA_W = 8,
  parameter int LANES  = 1,
  parameter int ACC_W  = 21
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         signed_mode,
  input  logic [LANES-1:0][DATA_W-1:0] a,
  input  logic [LANES-1:0][DATA_W-1:0] b,
  output logic [ACC_W-1:0]             partial
);

  localparam int PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0] sprod;
  logic [PROD_W-1:0] uprod;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  lane_sum;

  // Signed and unsigned products only agree modulo 2^DATA_W, so both are formed.
  always_comb begin
    sprod    = '0;
    uprod    = '0;
    prod     = '0;
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      sprod = $signed({{DATA_W{a[l][DATA_W-1]}}, a[l]}) *
              $signed({{DATA_W{b[l][DATA_W-1]}}, b[l]});
      uprod = {{DATA_W{1'b0}}, a[l]} * {{DATA_W{1'b0}}, b[l]};
      prod  = signed_mode ? sprod : uprod;
      lane_sum = lane_sum +
                 {{(ACC_W-PROD_W){signed_mode & prod[PROD_W-1]}}, prod};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      partial <= '0;
    end else if (en) begin
      partial <= lane_sum;
    end
  end

endmodule

// File: rtl/dot_product_engine.sv
// Multi-cycle dot product over VEC_LEN elements, LANES products per cycle,
// with optional accumulation onto the previous result for tiled rows.
module dot_product_engine
  import npu_pkg::*;
#(
  parameter int DATA_W  = NPU_DATA_W,
  parameter int VEC_LEN = NPU_VEC_LEN,
  parameter int LANES   = 1,
  parameter int ACC_W   = dot_acc_w(DATA_W, VEC_LEN)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           signed_mode,
  input  logic                           accum,
  input  logic [0:VEC_LEN-1][DATA_W-1:0] a,
  input  logic [0:VEC_LEN-1][DATA_W-1:0] b,
  output logic [ACC_W-1:0]               result,
  output logic                           busy,
  output logic                           done
);

  localparam int STEPS = VEC_LEN / LANES;
  localparam int IDX_W = $clog2(STEPS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STEPS - 1);

  dot_state_t                     state;
  logic [IDX_W-1:0]               index;
  logic [0:VEC_LEN-1][DATA_W-1:0] a_q;
  logic [0:VEC_LEN-1][DATA_W-1:0] b_q;
  logic                           sgn_q;
  logic [ACC_W-1:0]               acc;
  logic [ACC_W-1:0]               partial;
  logic [LANES-1:0][DATA_W-1:0]   lane_a;
  logic [LANES-1:0][DATA_W-1:0]   lane_b;

  always_comb begin
    lane_a = '0;
    lane_b = '0;
    if (state == RUN) begin
      for (int l = 0; l < LANES; l++) begin
        lane_a[l] = a_q[int'(index) * LANES + l];
        lane_b[l] = b_q[int'(index) * LANES + l];
      end
    end
  end

  dot_lane_mult #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .ACC_W  (ACC_W)
  ) u_lane_mult (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (state == RUN),
    .signed_mode (sgn_q),
    .a           (lane_a),
    .b           (lane_b),
    .partial     (partial)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      index  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
      acc    <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            sgn_q <= signed_mode;
            index <= '0;
            busy  <= 1'b1;
            acc   <= accum ? result : '0;
            state <= RUN;
          end
        end
        RUN: begin
          // The partial registered on the first RUN edge is not valid until the next.
          if (index != '0) begin
            acc <= acc + partial;
          end
          index <= index + 1'b1;
          if (index == LAST_IDX) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          result <= acc + partial;
          done   <= 1'b1;
          busy   <= 1'b0;
          index  <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_engine.sv
// Directed bench: a vector table for the default engine plus hand sequences
// for restart-while-busy, mid-operation reset and a LANES=4 back-to-back pair.
module tb_dot_product_engine;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic                 start4;
  logic                 signed_mode;
  logic                 accum;
  logic [0:31][7:0]     a;
  logic [0:31][7:0]     b;
  logic [20:0]          result;
  logic [20:0]          result4;
  logic                 busy, busy4;
  logic                 done, done4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dot_product_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .accum(accum), .a(a), .b(b), .result(result), .busy(busy), .done(done)
  );

  dot_product_engine #(.LANES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(signed_mode),
    .accum(accum), .a(a), .b(b), .result(result4), .busy(busy4), .done(done4)
  );

  typedef struct {
    string       name;
    logic [7:0]  av;
    logic [7:0]  bv;
    bit          ramp;
    bit          sgn;
    bit          acc;
    logic [20:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input logic [7:0] av, input logic [7:0] bv, input bit ramp);
    for (int i = 0; i < 32; i++) begin
      a[i] = ramp ? 8'(i) : av;
      b[i] = bv;
    end
  endtask

  // Entered at a negedge; returns edges elapsed until done is seen at a negedge.
  task automatic wait_done(input bit four, output int n, output int busy_n);
    n = 0;
    busy_n = 0;
    while (!(four ? done4 : done) && n < 100) begin
      busy_n += int'(four ? busy4 : busy);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input vec_t v);
    int n, bn;
    @(negedge clk);
    set_vec(v.av, v.bv, v.ramp);
    signed_mode = v.sgn;
    accum       = v.acc;
    start       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, n, bn);
    check({v.name, " latency"}, 64'(n), 64'd33);
    check({v.name, " busy cycles"}, 64'(bn), 64'd33);
    check({v.name, " result"}, 64'(result), 64'(v.exp));
    check({v.name, " busy at done"}, 64'(busy), 64'd0);
    @(negedge clk);
    check({v.name, " done pulse width"}, 64'(done), 64'd0);
  endtask

  vec_t tbl[10];

  initial begin
    int n, bn, pulses;

    tbl[0] = '{"u255",      8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 21'd2080800};
    tbl[1] = '{"u255 wrap", 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 21'd2064448};
    tbl[2] = '{"s-128sq",   8'h80, 8'h80, 1'b0, 1'b1, 1'b0, 21'd524288};
    tbl[3] = '{"s-1x1",     8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, 21'h1FFFE0};
    tbl[4] = '{"s-128x127", 8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 21'h181000};
    tbl[5] = '{"s-1x-1",    8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 21'd32};
    tbl[6] = '{"u255x1",    8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 21'd8160};
    tbl[7] = '{"ramp",      8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 21'd496};
    tbl[8] = '{"ramp acc",  8'h00, 8'h01, 1'b1, 1'b0, 1'b1, 21'd992};
    tbl[9] = '{"ramp again",8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 21'd496};

    rst_n = 1'b0;
    start = 1'b0;
    start4 = 1'b0;
    signed_mode = 1'b0;
    accum = 1'b0;
    set_vec(8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    check("reset result", 64'(result), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result4", 64'(result4), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_op(tbl[i]);

    // Restart attempt and operand changes while busy must not disturb the run.
    @(negedge clk);
    set_vec(8'h00, 8'h01, 1'b1);
    signed_mode = 1'b0;
    accum = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) begin @(posedge clk); @(negedge clk); end
    start = 1'b1;
    signed_mode = 1'b1;
    accum = 1'b1;
    set_vec(8'h7F, 8'h80, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("restart busy held", 64'(busy), 64'd1);
    wait_done(1'b0, n, bn);
    check("restart latency", 64'(n), 64'd27);
    check("restart result", 64'(result), 64'd496);
    pulses = 0;
    repeat (40) begin @(posedge clk); @(negedge clk); pulses += int'(done); end
    check("restart extra done", 64'(pulses), 64'd0);

    // Reset ten cycles into an operation.
    set_vec(8'hFF, 8'hFF, 1'b0);
    signed_mode = 1'b0;
    accum = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    #1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check("midreset result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op('{"post reset acc", 8'h00, 8'h01, 1'b1, 1'b0, 1'b1, 21'd496});

    // LANES=4: short latency and a start accepted in the done cycle.
    @(negedge clk);
    set_vec(8'h03, 8'h03, 1'b0);
    signed_mode = 1'b0;
    accum = 1'b0;
    start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    wait_done(1'b1, n, bn);
    check("l4 latency", 64'(n), 64'd9);
    check("l4 busy cycles", 64'(bn), 64'd9);
    check("l4 result", 64'(result4), 64'd288);
    set_vec(8'h02, 8'h02, 1'b0);
    start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    check("l4 b2b accepted", 64'(busy4), 64'd1);
    check("l4 b2b done low", 64'(done4), 64'd0);
    wait_done(1'b1, n, bn);
    check("l4 b2b latency", 64'(n), 64'd9);
    check("l4 b2b result", 64'(result4), 64'd128);
    @(negedge clk);
    check("l4 done pulse width", 64'(done4), 64'd0);
    check("l4 idle dut0 untouched", 64'(result), 64'd496);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
